// File: rtl/fxu_pkg.sv
// Shared types and widths for the FXU reservation-station bank.
package fxu_pkg;
  localparam int TAG_W  = 6;
  localparam int DATA_W = 16;
  localparam int OP_W   = 4;
  localparam int PC_W   = 16;

  localparam logic [OP_W-1:0] OP_MOV = 4'd0;
  localparam logic [OP_W-1:0] OP_ADD = 4'd1;
  localparam logic [OP_W-1:0] OP_JEQ = 4'd6;

  typedef enum logic [1:0] {
    RS_FREE   = 2'd0,
    RS_WAIT   = 2'd1,
    RS_READY  = 2'd2,
    RS_ISSUED = 2'd3
  } rs_state_t;
endpackage

// File: rtl/rs_entry.sv
// One reservation-station entry: state machine, CDB tag compare, operand capture.
// Updates at one edge from pre-edge state; issue is granted by the top-level select.
module rs_entry
  import fxu_pkg::*;
#(
  parameter logic [TAG_W-1:0] TAG = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alloc,
  input  logic              issue,
  input  logic [OP_W-1:0]   in_op,
  input  logic [PC_W-1:0]   in_pc,
  input  logic              in_busy0,
  input  logic              in_busy1,
  input  logic [TAG_W-1:0]  in_tag0,
  input  logic [TAG_W-1:0]  in_tag1,
  input  logic [DATA_W-1:0] in_val0,
  input  logic [DATA_W-1:0] in_val1,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_rs_num,
  input  logic [DATA_W-1:0] cdb_data,
  output logic              is_free,
  output logic              is_ready,
  output logic [OP_W-1:0]   op,
  output logic [PC_W-1:0]   pc,
  output logic [DATA_W-1:0] val0,
  output logic [DATA_W-1:0] val1
);
  rs_state_t         state_q, state_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              busy0_q, busy0_d, busy1_q, busy1_d;
  logic [TAG_W-1:0]  tag0_q, tag0_d, tag1_q, tag1_d;
  logic [DATA_W-1:0] val0_q, val0_d, val1_q, val1_d;

  logic hit0_in, hit1_in, hit0_q, hit1_q, retire_hit;

  assign hit0_in    = cdb_valid && (cdb_rs_num == in_tag0);
  assign hit1_in    = cdb_valid && (cdb_rs_num == in_tag1);
  assign hit0_q     = cdb_valid && busy0_q && (cdb_rs_num == tag0_q);
  assign hit1_q     = cdb_valid && busy1_q && (cdb_rs_num == tag1_q);
  assign retire_hit = cdb_valid && (cdb_rs_num == TAG);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    pc_d    = pc_q;
    busy0_d = busy0_q;
    busy1_d = busy1_q;
    tag0_d  = tag0_q;
    tag1_d  = tag1_q;
    val0_d  = val0_q;
    val1_d  = val1_q;
    case (state_q)
      RS_FREE: begin
        if (alloc) begin
          op_d    = in_op;
          pc_d    = in_pc;
          tag0_d  = in_tag0;
          tag1_d  = in_tag1;
          // An operand broadcast in the dispatch cycle is taken straight off the CDB.
          busy0_d = in_busy0 && !hit0_in;
          busy1_d = in_busy1 && !hit1_in;
          val0_d  = !in_busy0 ? in_val0 : (hit0_in ? cdb_data : '0);
          val1_d  = !in_busy1 ? in_val1 : (hit1_in ? cdb_data : '0);
          state_d = (busy0_d || busy1_d) ? RS_WAIT : RS_READY;
        end
      end
      RS_WAIT: begin
        if (hit0_q) begin
          busy0_d = 1'b0;
          val0_d  = cdb_data;
        end
        if (hit1_q) begin
          busy1_d = 1'b0;
          val1_d  = cdb_data;
        end
        if (!busy0_d && !busy1_d) state_d = RS_READY;
      end
      RS_READY: begin
        if (issue) state_d = retire_hit ? RS_FREE : RS_ISSUED;
      end
      RS_ISSUED: begin
        if (retire_hit) state_d = RS_FREE;
      end
      default: state_d = RS_FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RS_FREE;
      op_q    <= '0;
      pc_q    <= '0;
      busy0_q <= 1'b0;
      busy1_q <= 1'b0;
      tag0_q  <= '0;
      tag1_q  <= '0;
      val0_q  <= '0;
      val1_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      pc_q    <= pc_d;
      busy0_q <= busy0_d;
      busy1_q <= busy1_d;
      tag0_q  <= tag0_d;
      tag1_q  <= tag1_d;
      val0_q  <= val0_d;
      val1_q  <= val1_d;
    end
  end

  assign is_free  = (state_q == RS_FREE);
  assign is_ready = (state_q == RS_READY);
  assign op       = op_q;
  assign pc       = pc_q;
  assign val0     = val0_q;
  assign val1     = val1_q;
endmodule

// File: rtl/fxu_rs.sv
// FXU reservation-station bank: N entries, lowest-index alloc and issue selects.
// Issue is combinational from registered state, one per cycle; held while fxu_busy.
module fxu_rs
  import fxu_pkg::*;
#(
  parameter int N       = 4,
  parameter int RS_BASE = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [OP_W-1:0]   in_op,
  input  logic [PC_W-1:0]   in_pc,
  input  logic              in_busy0,
  input  logic              in_busy1,
  input  logic [TAG_W-1:0]  in_tag0,
  input  logic [TAG_W-1:0]  in_tag1,
  input  logic [DATA_W-1:0] in_val0,
  input  logic [DATA_W-1:0] in_val1,
  output logic              in_ready,
  output logic [TAG_W-1:0]  in_rs_num,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_rs_num,
  input  logic [DATA_W-1:0] cdb_data,
  input  logic              fxu_busy,
  output logic              valid,
  output logic [TAG_W-1:0]  rs_num,
  output logic [OP_W-1:0]   op,
  output logic [PC_W-1:0]   pc,
  output logic [DATA_W-1:0] val0,
  output logic [DATA_W-1:0] val1
);
  logic [N-1:0]      free_v, ready_v, alloc_v, issue_v;
  logic [OP_W-1:0]   e_op   [N];
  logic [PC_W-1:0]   e_pc   [N];
  logic [DATA_W-1:0] e_val0 [N];
  logic [DATA_W-1:0] e_val1 [N];
  logic [TAG_W-1:0]  alloc_idx, issue_idx;
  logic              any_ready;

  // Descending scan so the lowest index wins.
  always_comb begin
    alloc_idx = '0;
    issue_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (free_v[i])  alloc_idx = TAG_W'(i);
      if (ready_v[i]) issue_idx = TAG_W'(i);
    end
  end

  assign in_ready  = |free_v;
  assign in_rs_num = TAG_W'(RS_BASE) + alloc_idx;
  assign any_ready = |ready_v;
  assign valid     = any_ready && !fxu_busy;

  always_comb begin
    alloc_v = '0;
    issue_v = '0;
    if (in_valid && in_ready) alloc_v[alloc_idx] = 1'b1;
    if (valid)                issue_v[issue_idx] = 1'b1;
  end

  always_comb begin
    rs_num = '0;
    op     = '0;
    pc     = '0;
    val0   = '0;
    val1   = '0;
    if (valid) begin
      rs_num = TAG_W'(RS_BASE) + issue_idx;
      op     = e_op[issue_idx];
      pc     = e_pc[issue_idx];
      val0   = e_val0[issue_idx];
      val1   = e_val1[issue_idx];
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_ent
    rs_entry #(
      .TAG(TAG_W'(RS_BASE + g))
    ) u_ent (
      .clk        (clk),
      .reset      (reset),
      .alloc      (alloc_v[g]),
      .issue      (issue_v[g]),
      .in_op      (in_op),
      .in_pc      (in_pc),
      .in_busy0   (in_busy0),
      .in_busy1   (in_busy1),
      .in_tag0    (in_tag0),
      .in_tag1    (in_tag1),
      .in_val0    (in_val0),
      .in_val1    (in_val1),
      .cdb_valid  (cdb_valid),
      .cdb_rs_num (cdb_rs_num),
      .cdb_data   (cdb_data),
      .is_free    (free_v[g]),
      .is_ready   (ready_v[g]),
      .op         (e_op[g]),
      .pc         (e_pc[g]),
      .val0       (e_val0[g]),
      .val1       (e_val1[g])
    );
  end
endmodule

// File: tb/tb_fxu_rs.sv
// Directed bench for fxu_rs: dispatch, bypass, capture, backpressure, retire, reset.
module tb_fxu_rs;
  import fxu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [3:0]  in_op;
  logic [15:0] in_pc;
  logic        in_busy0, in_busy1;
  logic [5:0]  in_tag0, in_tag1;
  logic [15:0] in_val0, in_val1;
  logic        in_ready;
  logic [5:0]  in_rs_num;
  logic        cdb_valid;
  logic [5:0]  cdb_rs_num;
  logic [15:0] cdb_data;
  logic        fxu_busy;
  logic        valid;
  logic [5:0]  rs_num;
  logic [3:0]  op;
  logic [15:0] pc, val0, val1;

  int n_vec = 0;
  int n_bad = 0;

  fxu_rs #(.N(4), .RS_BASE(0)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_op(in_op), .in_pc(in_pc),
    .in_busy0(in_busy0), .in_busy1(in_busy1),
    .in_tag0(in_tag0), .in_tag1(in_tag1),
    .in_val0(in_val0), .in_val1(in_val1),
    .in_ready(in_ready), .in_rs_num(in_rs_num),
    .cdb_valid(cdb_valid), .cdb_rs_num(cdb_rs_num), .cdb_data(cdb_data),
    .fxu_busy(fxu_busy),
    .valid(valid), .rs_num(rs_num), .op(op), .pc(pc), .val0(val0), .val1(val1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1ns after the edge; outputs are checked 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic dispatch(input logic [3:0] o, input logic [15:0] p,
                          input logic b0, input logic [5:0] t0, input logic [15:0] v0,
                          input logic b1, input logic [5:0] t1, input logic [15:0] v1);
    in_valid = 1'b1; in_op = o; in_pc = p;
    in_busy0 = b0; in_tag0 = t0; in_val0 = v0;
    in_busy1 = b1; in_tag1 = t1; in_val1 = v1;
  endtask

  task automatic idle_in();
    in_valid = 1'b0; in_op = '0; in_pc = '0;
    in_busy0 = 1'b0; in_tag0 = '0; in_val0 = '0;
    in_busy1 = 1'b0; in_tag1 = '0; in_val1 = '0;
  endtask

  task automatic cdb(input logic v, input logic [5:0] t, input logic [15:0] d);
    cdb_valid = v; cdb_rs_num = t; cdb_data = d;
  endtask

  initial begin
    reset = 1'b1;
    fxu_busy = 1'b0;
    idle_in();
    cdb(1'b0, '0, '0);
    tick(); tick();
    reset = 1'b0;
    settle();

    // Reset state
    chk("rst_valid", valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_in_rs_num", in_rs_num, 0);
    chk("rst_rs_num", rs_num, 0);
    chk("rst_pc", pc, 0);
    chk("rst_val0", val0, 0);

    // ADD with both operands present: issue the cycle after dispatch
    dispatch(OP_ADD, 16'h0010, 0, 0, 16'd3, 0, 0, 16'd4);
    settle();
    chk("add_in_rs_num", in_rs_num, 0);
    chk("add_no_early_valid", valid, 0);
    tick(); idle_in(); settle();
    chk("add_valid", valid, 1);
    chk("add_rs_num", rs_num, 0);
    chk("add_op", op, 1);
    chk("add_pc", pc, 16'h0010);
    chk("add_val0", val0, 3);
    chk("add_val1", val1, 4);
    tick(); settle();
    chk("add_issued_valid", valid, 0);
    chk("add_issued_occupied", in_rs_num, 1);
    cdb(1, 0, 16'h1234); settle();
    chk("retire_cycle_not_alloc", in_rs_num, 1);
    tick(); cdb(0, 0, 0); settle();
    chk("add_retired_rs_num", in_rs_num, 0);
    chk("add_retired_ready", in_ready, 1);

    // MOV waiting on tag 9, broadcast two cycles later
    dispatch(OP_MOV, 16'h0020, 1, 6'd9, 16'hDEAD, 0, 0, 16'd7);
    tick(); idle_in(); settle();
    chk("mov_wait_c1", valid, 0);
    tick(); settle();
    chk("mov_wait_c2", valid, 0);
    cdb(1, 6'd9, 16'hBEEF); settle();
    chk("mov_bcast_cycle", valid, 0);
    tick(); cdb(0, 0, 0); settle();
    chk("mov_valid", valid, 1);
    chk("mov_rs_num", rs_num, 0);
    chk("mov_op", op, 0);
    chk("mov_val0", val0, 16'hBEEF);
    chk("mov_val1", val1, 7);
    tick(); cdb(1, 0, 0); tick(); cdb(0, 0, 0); settle();
    chk("mov_retired", in_rs_num, 0);

    // Same-cycle bypass on operand 1
    dispatch(OP_JEQ, 16'h0040, 0, 0, 16'h0011, 1, 6'd5, 16'hFFFF);
    cdb(1, 6'd5, 16'h0042);
    tick(); idle_in(); cdb(0, 0, 0); settle();
    chk("byp_valid", valid, 1);
    chk("byp_op", op, 6);
    chk("byp_val0", val0, 16'h0011);
    chk("byp_val1", val1, 16'h0042);
    tick(); cdb(1, 0, 0); tick(); cdb(0, 0, 0); settle();

    // Fill all entries under fxu_busy; 5th dispatch dropped
    fxu_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dispatch(OP_ADD, 16'h0100 + 16'(i), 0, 0, 16'(i), 0, 0, 16'h00A0 + 16'(i));
      settle();
      chk("fill_in_rs_num", in_rs_num, i);
      tick();
    end
    idle_in(); settle();
    chk("full_in_ready", in_ready, 0);
    chk("full_busy_valid", valid, 0);
    dispatch(OP_MOV, 16'h0200, 0, 0, 16'h5555, 0, 0, 16'h5555);
    tick(); idle_in(); settle();
    chk("drop_in_ready", in_ready, 0);
    chk("busy_hold_valid", valid, 0);
    fxu_busy = 1'b0; settle();
    for (int i = 0; i < 4; i++) begin
      chk("drain_valid", valid, 1);
      chk("drain_rs_num", rs_num, i);
      chk("drain_pc", pc, 16'h0100 + 16'(i));
      chk("drain_val1", val1, 16'h00A0 + 16'(i));
      tick();
    end
    chk("drained_valid", valid, 0);
    chk("issued_count_full", in_ready, 0);
    for (int i = 0; i < 4; i++) begin
      cdb(1, 6'(i), 16'h0);
      tick();
    end
    cdb(0, 0, 0); settle();
    chk("all_retired_ready", in_ready, 1);
    chk("all_retired_rs_num", in_rs_num, 0);

    // Issue and own-tag retire in the same cycle, then reallocate tag 0
    dispatch(OP_ADD, 16'h0030, 0, 0, 16'd1, 0, 0, 16'd2);
    tick(); idle_in(); cdb(1, 0, 16'h0); settle();
    chk("sameret_valid", valid, 1);
    chk("sameret_rs_num", rs_num, 0);
    tick(); cdb(0, 0, 0); settle();
    chk("sameret_free_valid", valid, 0);
    chk("sameret_free_rs_num", in_rs_num, 0);
    dispatch(OP_ADD, 16'h0031, 0, 0, 16'd5, 0, 0, 16'd6);
    tick(); idle_in(); cdb(1, 0, 16'h0); settle();
    chk("realloc_rs_num", rs_num, 0);
    chk("realloc_pc", pc, 16'h0031);
    tick(); cdb(0, 0, 0); settle();

    // Reset mid-run discards waiting entries
    dispatch(OP_MOV, 16'h0050, 1, 6'd10, 0, 0, 0, 0);
    tick();
    dispatch(OP_MOV, 16'h0051, 1, 6'd11, 0, 0, 0, 0);
    tick(); idle_in(); settle();
    chk("pre_rst_rs_num", in_rs_num, 2);
    reset = 1'b1;
    tick(); reset = 1'b0; settle();
    chk("midrst_valid", valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_in_rs_num", in_rs_num, 0);
    cdb(1, 6'd10, 16'h7777); tick();
    cdb(1, 6'd11, 16'h8888); tick();
    cdb(0, 0, 0); settle();
    chk("post_rst_cdb_valid", valid, 0);
    chk("post_rst_cdb_rs_num", in_rs_num, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/fxu_rs.md
# fxu_rs

Reservation-station bank feeding the fixed-point unit (FXU): the issuing end of the FXU request interface. Holds up to `N` dispatched MOV/ADD/JEQ instructions and captures missing operands from the common data bus (CDB). Issues one operand-complete instruction per cycle to the FXU and keeps each entry's tag reserved until its result has been broadcast.

## Interface
- `N`, 4: number of entries (1..16).
- `RS_BASE`, 0: tag of entry 0. Entry i owns tag `RS_BASE+i`; `RS_BASE+N-1` must be ≤ 63.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `in_valid` in 1: dispatch request from decode.
- `in_op` in 4: opcode (MOV=0, ADD=1, JEQ=6).
- `in_pc` in 16: instruction PC.
- `in_busy0`, `in_busy1` in 1: operand not yet produced; `in_tagX` is valid, `in_valX` is ignored.
- `in_tag0`, `in_tag1` in 6: producer tag when busy.
- `in_val0`, `in_val1` in 16: operand value when not busy.
- `in_ready` out 1: a FREE entry exists. Combinational from state.
- `in_rs_num` out 6: tag the current request will receive. Valid when `in_ready`.
- `cdb_valid` in 1, `cdb_rs_num` in 6, `cdb_data` in 16: result broadcast.
- `fxu_busy` in 1: FXU cannot accept an issue this cycle.
- `valid`, `rs_num` (6), `op` (4), `pc` (16), `val0`, `val1` (16) out: FXU issue port.

## Operation
- Entry states: FREE, WAIT (≥1 operand busy), READY, ISSUED. The state type is 2 bits.
- Allocate:
  - Fires when `in_valid && in_ready`. Takes the lowest-index FREE entry.
  - Latches op, pc and operands.
  - Next state is READY if both operands are present after CDB bypass, otherwise WAIT.
  - `in_valid` while `!in_ready` is dropped; no state change.
- Bypass: an incoming busy operand whose `in_tagX == cdb_rs_num` with `cdb_valid` in the same cycle captures `cdb_data` and is marked present.
- Capture: every WAIT entry compares both pending tags against the CDB each cycle and latches `cdb_data` on match. It moves to READY at the edge where its last operand arrives.
- Issue:
  - Select the lowest-index READY entry.
  - If one exists and `!fxu_busy`, drive `valid=1` with `rs_num` set to the entry tag and its op/pc/val0/val1. These outputs are combinational from registered state.
  - The entry becomes ISSUED at the edge.
  - When `valid=0`, the data outputs are 0.
- Retire:
  - An ISSUED entry returns to FREE when `cdb_valid && cdb_rs_num == own tag`.
  - If an entry is issued and its own tag appears on the CDB in the same cycle, it goes directly to FREE.
  - A CDB tag outside `[RS_BASE, RS_BASE+N-1]` affects only WAIT capture.
- Same-cycle events:
  - Allocation, capture, issue and retire all evaluate from pre-edge state and update at one edge.
  - An entry freed this cycle is not allocatable until the next cycle.
- No operand arithmetic is done here; values pass through unmodified at 16 bits.

## Timing
- Reset: all entries FREE and all stored fields 0. Outputs: `valid=0`, data outputs 0, `in_ready=1`, `in_rs_num=RS_BASE`.
- Reset mid-operation discards all entries, including ISSUED ones. Later CDB traffic for discarded tags is ignored.
- Allocate with both operands present at edge T: `valid=1` in cycle T+1 if `!fxu_busy`.
- Operand arrives on the CDB in cycle C: entry READY after edge C, earliest issue in cycle C+1.
- `fxu_busy` high: the selected entry stays READY and is re-selected every cycle, with no loss.
- Throughput: one issue per cycle. Full means all N entries are non-FREE; ISSUED entries count as occupied.

## Structure
- Shared package `fxu_pkg`:
  - opcode constants MOV/ADD/JEQ;
  - `rs_state_t` enum;
  - tag width (6) and data width (16).
- Sub-module `rs_entry`: one entry's state machine, tag compare and operand capture, instantiated N times.
- The top level holds the two lowest-index priority selects (alloc, issue) and the output mux.

## Test plan
- Reset, then dispatch ADD pc=0x10 val0=3 val1=4 → `in_rs_num=0`; next cycle `valid=1`, rs_num=0, op=1, val0=3, val1=4. Then CDB tag 0 → entry 0 FREE.
- Dispatch MOV with busy0 tag=9, then CDB 9/0xBEEF two cycles later → no issue until the cycle after the broadcast, then `val0=0xBEEF`.
- Dispatch with busy1 tag=5 while CDB carries 5/0x0042 in the same cycle → issues next cycle with `val1=0x0042`.
- Fill 4 entries with ready ops and hold `fxu_busy=1` → `in_ready=0`, a 5th `in_valid` is dropped. Release `fxu_busy` → issues in order tags 0,1,2,3.
- Issue an entry and broadcast its own tag the same cycle → FREE next cycle; it is allocated again with the same tag.
- Two WAIT entries, then `reset` asserted mid-run → all FREE, `valid=0`. A later CDB of their tags causes no issue.
